// File: rtl/spoofer_checker_avst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spoofer_pkg
//  Description : Shared types and helpers for the spoofer AVST checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package spoofer_pkg;

    localparam int c_avst_chk_state_n = 3;
    localparam int c_avst_chk_state_w = $clog2(c_avst_chk_state_n);

    typedef enum logic [c_avst_chk_state_w-1:0] {
        IDLE   = c_avst_chk_state_w'(0),
        SYNC   = c_avst_chk_state_w'(1),
        LOCKED = c_avst_chk_state_w'(2)
    } avst_chk_state_t;

    // Widest counter the saturating helper supports; callers cast in and out.
    localparam int c_sat_max_w = 64;

    function automatic logic [c_sat_max_w-1:0] sat_inc(
        input logic [c_sat_max_w-1:0] value,
        input logic [c_sat_max_w-1:0] max
    );
        return (value >= max) ? value : value + c_sat_max_w'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spoofer_checker_avst_if.sv
`default_nettype none
// ============================================================================
//  Module      : spoofer_checker_avst_if
//  Description : Avalon-ST beat bundle (ready latency 0) between source and sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spoofer_checker_avst_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/spoofer_checker_avst_ready_throttle.sv
`default_nettype none
// ============================================================================
//  Module      : avst_ready_throttle
//  Description : Periodic ready pattern: high for READY_ON of every READY_PERIOD cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module avst_ready_throttle #(
    parameter int unsigned READY_PERIOD = 4,
    parameter int unsigned READY_ON     = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic run,
    output logic      ready
);

    localparam int unsigned c_phase_w = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [c_phase_w-1:0] c_phase_last = c_phase_w'(READY_PERIOD - 1);

    logic [c_phase_w-1:0] r_phase;

    // Phase restarts from 0 whenever the checker is idle, so every run
    // begins with the ready-high part of the pattern.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_phase <= '0;
        end else if (r_phase == c_phase_last) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_phase_w'(1);
        end
    end

    assign ready = run && (32'(r_phase) < READY_ON);

endmodule
`default_nettype wire

// File: rtl/spoofer_checker_avst.sv
`default_nettype none
// ============================================================================
//  Module      : spoofer_checker_avst
//  Description : AVST sink checking an incrementing word stream, with error capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module spoofer_checker_avst
    import spoofer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CNT_WIDTH    = 16,
    parameter int READY_PERIOD = 4,
    parameter int READY_ON     = 3
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    spoofer_checker_avst_if.slave      st,
    input  wire logic                  enable,
    input  wire logic                  clear,
    output logic                       locked,
    output logic [CNT_WIDTH-1:0]       word_count,
    output logic [CNT_WIDTH-1:0]       err_count,
    output logic                       first_err_valid,
    output logic [DATA_WIDTH-1:0]      first_err_expected,
    output logic [DATA_WIDTH-1:0]      first_err_actual
);

    localparam logic [c_sat_max_w-1:0] c_cnt_max = c_sat_max_w'({CNT_WIDTH{1'b1}});

    avst_chk_state_t       r_state;
    avst_chk_state_t       w_state_next;
    logic                  w_run;
    logic                  w_ready;
    logic                  w_beat;
    logic                  w_mismatch;
    logic [DATA_WIDTH-1:0] r_expected;
    logic                  r_locked;
    logic [CNT_WIDTH-1:0]  r_word_count;
    logic [CNT_WIDTH-1:0]  r_err_count;
    logic                  r_first_err_valid;
    logic [DATA_WIDTH-1:0] r_first_err_expected;
    logic [DATA_WIDTH-1:0] r_first_err_actual;
    logic [CNT_WIDTH-1:0]  w_word_inc;
    logic [CNT_WIDTH-1:0]  w_err_inc;

    assign w_run = (r_state != IDLE);

    avst_ready_throttle #(
        .READY_PERIOD (READY_PERIOD),
        .READY_ON     (READY_ON)
    ) u_throttle (
        .clk   (clk),
        .rst   (rst),
        .run   (w_run),
        .ready (w_ready)
    );

    assign st.ready   = w_ready;
    assign w_beat     = st.valid && w_ready;
    assign w_mismatch = (r_state == LOCKED) && (st.data != r_expected);
    assign w_word_inc = CNT_WIDTH'(sat_inc(c_sat_max_w'(r_word_count), c_cnt_max));
    assign w_err_inc  = CNT_WIDTH'(sat_inc(c_sat_max_w'(r_err_count), c_cnt_max));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable) w_state_next = SYNC;
            SYNC:    if (w_beat) w_state_next = LOCKED;
            LOCKED:  w_state_next = LOCKED;
            default: w_state_next = IDLE;
        endcase
        if (!enable) begin
            w_state_next = IDLE;
        end
    end

    // A beat on the edge that drops enable is still counted and checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_expected           <= '0;
            r_locked             <= 1'b0;
            r_word_count         <= '0;
            r_err_count          <= '0;
            r_first_err_valid    <= 1'b0;
            r_first_err_expected <= '0;
            r_first_err_actual   <= '0;
        end else begin
            if (w_beat) begin
                r_expected <= st.data + DATA_WIDTH'(1);
            end

            if (!enable) begin
                r_locked <= 1'b0;
            end else if ((r_state == SYNC) && w_beat) begin
                r_locked <= 1'b1;
            end

            // Clear beats a simultaneous beat for the counters only.
            if (clear) begin
                r_word_count         <= '0;
                r_err_count          <= '0;
                r_first_err_valid    <= 1'b0;
                r_first_err_expected <= '0;
                r_first_err_actual   <= '0;
            end else if (w_beat) begin
                r_word_count <= w_word_inc;
                if (w_mismatch) begin
                    r_err_count <= w_err_inc;
                    if (!r_first_err_valid) begin
                        r_first_err_valid    <= 1'b1;
                        r_first_err_expected <= r_expected;
                        r_first_err_actual   <= st.data;
                    end
                end
            end
        end
    end

    assign locked             = r_locked;
    assign word_count         = r_word_count;
    assign err_count          = r_err_count;
    assign first_err_valid    = r_first_err_valid;
    assign first_err_expected = r_first_err_expected;
    assign first_err_actual   = r_first_err_actual;

endmodule
`default_nettype wire

// File: tb/tb_spoofer_checker_avst.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spoofer_checker_avst
//  Description : Bench for spoofer_checker_avst against a behavioural stream model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spoofer_checker_avst;

    localparam int c_p  = 4;
    localparam int c_on = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;

    logic        locked_a, fev_a;
    logic [15:0] wc_a, err_a;
    logic [31:0] fee_a, fea_a;
    logic        locked_b, fev_b;
    logic [1:0]  wc_b, err_b;
    logic [31:0] fee_b, fea_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    spoofer_checker_avst_if #(.DATA_WIDTH(32)) st_a ();
    spoofer_checker_avst_if #(.DATA_WIDTH(32)) st_b ();
    assign st_a.valid = valid;
    assign st_a.data  = data;
    assign st_b.valid = valid;
    assign st_b.data  = data;

    spoofer_checker_avst #(
        .DATA_WIDTH(32), .CNT_WIDTH(16), .READY_PERIOD(c_p), .READY_ON(c_on)
    ) dut (
        .clk(clk), .rst(rst), .st(st_a), .enable(enable), .clear(clear),
        .locked(locked_a), .word_count(wc_a), .err_count(err_a),
        .first_err_valid(fev_a), .first_err_expected(fee_a), .first_err_actual(fea_a)
    );

    spoofer_checker_avst #(
        .DATA_WIDTH(32), .CNT_WIDTH(2), .READY_PERIOD(c_p), .READY_ON(c_on)
    ) dut_small (
        .clk(clk), .rst(rst), .st(st_b), .enable(enable), .clear(clear),
        .locked(locked_b), .word_count(wc_b), .err_count(err_b),
        .first_err_valid(fev_b), .first_err_expected(fee_b), .first_err_actual(fea_b)
    );

    // Behavioural model: mode 0 idle, 1 waiting for first word, 2 tracking.
    int          m_mode = 0;
    int          m_k = 0;
    logic [31:0] m_exp = '0;
    int          m_words = 0;
    int          m_errs = 0;
    bit          m_locked = 0;
    bit          m_fev = 0;
    logic [31:0] m_fee = '0;
    logic [31:0] m_fea = '0;

    function automatic bit m_ready();
        return (m_mode != 0) && ((m_k % c_p) < c_on);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step();
        bit beat;
        int mode_now;
        if (rst) begin
            m_mode = 0; m_k = 0; m_exp = '0; m_words = 0; m_errs = 0;
            m_locked = 0; m_fev = 0; m_fee = '0; m_fea = '0;
        end else begin
            beat     = valid && m_ready();
            mode_now = m_mode;
            m_k      = (m_mode != 0) ? m_k + 1 : 0;
            if (clear) begin
                m_words = 0; m_errs = 0; m_fev = 0; m_fee = '0; m_fea = '0;
            end else if (beat) begin
                m_words++;
                if (mode_now == 2 && data != m_exp) begin
                    m_errs++;
                    if (!m_fev) begin
                        m_fev = 1; m_fee = m_exp; m_fea = data;
                    end
                end
            end
            if (beat) m_exp = data + 32'd1;
            if (!enable) begin
                m_mode = 0; m_locked = 0;
            end else if (mode_now == 0) begin
                m_mode = 1;
            end else if (mode_now == 1 && beat) begin
                m_mode = 2; m_locked = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",       64'(st_a.ready), 64'(m_ready()));
            chk("ready_small", 64'(st_b.ready), 64'(m_ready()));
            chk("locked",      64'(locked_a),   64'(m_locked));
            chk("word_count",  64'(wc_a),       64'(sat(m_words, 65535)));
            chk("err_count",   64'(err_a),      64'(sat(m_errs, 65535)));
            chk("fev",         64'(fev_a),      64'(m_fev));
            chk("fee",         64'(fee_a),      64'(m_fee));
            chk("fea",         64'(fea_a),      64'(m_fea));
            chk("locked_small",64'(locked_b),   64'(m_locked));
            chk("wc_small",    64'(wc_b),       64'(sat(m_words, 3)));
            chk("err_small",   64'(err_b),      64'(sat(m_errs, 3)));
            chk("fee_small",   64'(fee_b),      64'(m_fee));
        end
    end

    // Inputs change right after a falling edge; the model advances on the rising edge.
    task automatic tick(input logic v, input logic [31:0] d, input logic en,
                        input logic clr, input logic r);
        valid = v; data = d; enable = en; clear = clr; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] d);
        bit rdy;
        for (int t = 0; t < 20; t++) begin
            rdy = m_ready();
            tick(1'b1, d, 1'b1, 1'b0, 1'b0);
            if (rdy) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no beat for word %0h within 20 cycles", d);
    endtask

    initial begin
        int          pat[8];
        logic [31:0] src;
        logic [31:0] d;
        logic        v, en, clr, r;
        bit          rdy;

        pat = '{1, 1, 1, 0, 1, 1, 1, 0};
        @(negedge clk);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 64'(st_a.ready), 64'd0);
        chk("rst_wc", 64'(wc_a), 64'd0);

        // Ready pattern starting the cycle after entering SYNC
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("ready_pattern", 64'(st_a.ready), 64'(pat[i]));
            if (i < 7) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        end

        for (int w = 5; w <= 8; w++) send_word(32'(w));
        chk("lit_locked", 64'(locked_a), 64'd1);
        chk("lit_wc4", 64'(wc_a), 64'd4);
        chk("lit_err0", 64'(err_a), 64'd0);
        chk("lit_fev0", 64'(fev_a), 64'd0);

        // Resync with a cleared set of counters, then a single dropped word
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        send_word(32'd10); send_word(32'd11); send_word(32'd13); send_word(32'd14);
        chk("lit_err1", 64'(err_a), 64'd1);
        chk("lit_fee12", 64'(fee_a), 64'd12);
        chk("lit_fea13", 64'(fea_a), 64'd13);

        tick(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        send_word(32'hFFFF_FFFE); send_word(32'hFFFF_FFFF);
        send_word(32'h0); send_word(32'h1); send_word(32'h2);
        chk("lit_wrap_err0", 64'(err_a), 64'd0);
        chk("lit_wc5", 64'(wc_a), 64'd5);
        chk("lit_small_sat", 64'(wc_b), 64'd3);

        // Valid with changing data during a backpressure cycle
        for (int t = 0; t < 8 && m_ready(); t++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 32'hDEAD_0000 ^ $urandom, 1'b1, 1'b0, 1'b0);
        chk("lit_stall_wc", 64'(wc_a), 64'd5);
        chk("lit_stall_err", 64'(err_a), 64'd0);

        for (int t = 0; t < 8 && !m_ready(); t++) tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 32'd3, 1'b1, 1'b1, 1'b0);
        chk("lit_clear_beat", 64'(wc_a), 64'd0);
        send_word(32'd4);
        chk("lit_after_clear_wc", 64'(wc_a), 64'd1);
        chk("lit_after_clear_err", 64'(err_a), 64'd0);

        send_word(32'd7); send_word(32'd9);
        chk("lit_err2", 64'(err_a), 64'd2);
        tick(1'b1, 32'd10, 1'b1, 1'b0, 1'b1);
        chk("lit_rst_ready", 64'(st_a.ready), 64'd0);
        chk("lit_rst_locked", 64'(locked_a), 64'd0);
        chk("lit_rst_err", 64'(err_a), 64'd0);
        chk("lit_rst_wc", 64'(wc_a), 64'd0);

        // Randomized traffic: mostly in-sequence words with occasional glitches
        src = 32'($urandom);
        en  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            clr = ($urandom_range(0, 63) == 0);
            r   = ($urandom_range(0, 499) == 0);
            v   = ($urandom_range(0, 9) < 7);
            d   = ($urandom_range(0, 7) == 0) ? 32'($urandom) : src;
            rdy = m_ready();
            tick(v, d, en, clr, r);
            if (v && rdy && !r) src = d + 32'd1;
        end

        tick(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no end of test, expected finish within bound");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
